// File: rtl/counter_updown_mod.sv
// ============================================================================
// counter_updown_mod : up/down counter with load, clear, dual enables, rco and
// registered wrap pulse. Optional macro COUNTER_SATURATE_EN holds at bounds.
// Revision: 1.0
// ============================================================================
`default_nettype none

module counter_updown_mod #(
  parameter int unsigned WIDTH       = 8,
  parameter int unsigned MAX_VALUE   = 2**WIDTH - 1,
  parameter int unsigned RESET_VALUE = 0
) (
  input  logic             clk,
  input  logic             resetN,
  input  logic [1:0]       s,
  input  logic             enpN,
  input  logic             entN,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             rcoN,
  output logic             wrap
);

  localparam logic [WIDTH-1:0] c_MAX   = MAX_VALUE[WIDTH-1:0];
  localparam logic [WIDTH-1:0] c_RESET = RESET_VALUE[WIDTH-1:0];
  localparam logic [1:0]       c_CLEAR = 2'b00;
  localparam logic [1:0]       c_DOWN  = 2'b01;
  localparam logic [1:0]       c_LOAD  = 2'b10;
  localparam logic [1:0]       c_UP    = 2'b11;

  logic [WIDTH-1:0] r_q;
  logic             r_wrap;
  logic [WIDTH-1:0] w_q_nxt;
  logic             w_wrap_nxt;
  logic             w_en;
  logic             w_at_top;
  logic             w_at_bot;

  assign w_en     = !enpN && !entN;
  assign w_at_top = (r_q >= c_MAX);
  // Out-of-range values (loaded above MAX) count as a bound in the down direction too.
  assign w_at_bot = (r_q == '0) || (r_q > c_MAX);

  always_comb begin
    w_q_nxt    = r_q;
    w_wrap_nxt = 1'b0;
    case (s)
      c_LOAD: w_q_nxt = d;
      c_CLEAR: begin
        if (w_en) w_q_nxt = '0;
      end
      c_UP: begin
        if (w_en) begin
          if (w_at_top) begin
`ifdef COUNTER_SATURATE_EN
            w_q_nxt = c_MAX;
`else
            w_q_nxt = '0;
`endif
            w_wrap_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q + 1'b1;
          end
        end
      end
      c_DOWN: begin
        if (w_en) begin
          if (w_at_bot) begin
`ifdef COUNTER_SATURATE_EN
            w_q_nxt = (r_q == '0) ? '0 : c_MAX;
`else
            w_q_nxt = c_MAX;
`endif
            w_wrap_nxt = 1'b1;
          end else begin
            w_q_nxt = r_q - 1'b1;
          end
        end
      end
      default: w_q_nxt = r_q;
    endcase
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      r_q    <= c_RESET;
      r_wrap <= 1'b0;
    end else begin
      r_q    <= w_q_nxt;
      r_wrap <= w_wrap_nxt;
    end
  end

  assign q    = r_q;
  assign wrap = r_wrap;
  assign rcoN = !(!entN && (((s == c_UP) && w_at_top) || ((s == c_DOWN) && w_at_bot)));

endmodule

`default_nettype wire

// File: tb/tb_counter_updown_mod.sv
// Bench for counter_updown_mod (WIDTH=4, MAX_VALUE=9), honours COUNTER_SATURATE_EN.
`default_nettype none

module tb_counter_updown_mod;

  localparam int MAXV = 9;
`ifdef COUNTER_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       resetN;
  logic [1:0] s;
  logic       enpN, entN;
  logic [3:0] d;
  logic [3:0] q;
  logic       rcoN, wrap;

  logic       c_resetN;
  logic [1:0] c_s;
  logic       c_enpN;
  logic [3:0] c_q_lo, c_q_hi;
  logic       c_rco_lo, c_rco_hi, c_wrap_lo, c_wrap_hi;

  int checks = 0;
  int errors = 0;
  int m_q    = 0;
  bit m_wrap = 1'b0;

  always #5 clk = ~clk;

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(MAXV), .RESET_VALUE(0)) u_dut (
    .clk(clk), .resetN(resetN), .s(s), .enpN(enpN), .entN(entN),
    .d(d), .q(q), .rcoN(rcoN), .wrap(wrap)
  );

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(MAXV), .RESET_VALUE(0)) u_lo (
    .clk(clk), .resetN(c_resetN), .s(c_s), .enpN(c_enpN), .entN(1'b0),
    .d(4'd0), .q(c_q_lo), .rcoN(c_rco_lo), .wrap(c_wrap_lo)
  );

  counter_updown_mod #(.WIDTH(4), .MAX_VALUE(MAXV), .RESET_VALUE(0)) u_hi (
    .clk(clk), .resetN(c_resetN), .s(c_s), .enpN(c_enpN), .entN(c_rco_lo),
    .d(4'd0), .q(c_q_hi), .rcoN(c_rco_hi), .wrap(c_wrap_hi)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Reference: counting range is the ring 0..MAXV; anything outside is a bound.
  function automatic bit model_rco();
    bit top, bot;
    top = (m_q >= MAXV);
    bot = (m_q == 0) || (m_q > MAXV);
    return !(!entN && ((s == 2'b11 && top) || (s == 2'b01 && bot)));
  endfunction

  task automatic model_edge();
    bit en;
    en     = !enpN && !entN;
    m_wrap = 1'b0;
    if (s == 2'b10) m_q = int'(d);
    else if (en) begin
      if (s == 2'b00) m_q = 0;
      else if (s == 2'b11) begin
        if (m_q >= MAXV) begin
          m_wrap = 1'b1;
          m_q    = SAT ? MAXV : 0;
        end else m_q = (m_q + 1) % (MAXV + 1);
      end else begin
        if (m_q == 0 || m_q > MAXV) begin
          m_wrap = 1'b1;
          m_q    = (SAT && m_q == 0) ? 0 : MAXV;
        end else m_q = m_q - 1;
      end
    end
  endtask

  task automatic drive(input logic [1:0] ns, input logic np, input logic nt, input logic [3:0] nd);
    s = ns; enpN = np; entN = nt; d = nd;
    #1;
    check("rcoN", 32'(rcoN), 32'(model_rco()));
  endtask

  task automatic tick(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check({tag, ".q"}, 32'(q), 32'(m_q));
    check({tag, ".wrap"}, 32'(wrap), 32'(m_wrap));
    @(negedge clk);
  endtask

  initial begin
    resetN = 1'b0; s = 2'b00; enpN = 1'b1; entN = 1'b1; d = '0;
    c_resetN = 1'b0; c_s = 2'b11; c_enpN = 1'b1;
    #1;
    check("reset.q", 32'(q), 0);
    check("reset.wrap", 32'(wrap), 0);
    check("reset.rcoN", 32'(rcoN), 1);
    @(negedge clk);
    @(negedge clk);
    resetN = 1'b1;

    // count to 5, then async reset mid-count
    drive(2'b11, 1'b0, 1'b0, 4'd0);
    for (int i = 0; i < 5; i++) tick("pre");
    check("pre.q5", 32'(q), 5);
    #2 resetN = 1'b0;
    #1;
    m_q = 0; m_wrap = 1'b0;
    check("async.q", 32'(q), 0);
    check("async.wrap", 32'(wrap), 0);
    @(negedge clk);
    resetN = 1'b1;

    // 12 up counts: 1..9,0,1,2
    for (int i = 0; i < 12; i++) begin
      drive(2'b11, 1'b0, 1'b0, 4'd0);
      tick("up");
    end
    check("up.end", 32'(q), 2);

    // down from 0
    drive(2'b00, 1'b0, 1'b0, 4'd0);
    tick("clr");
    drive(2'b01, 1'b0, 1'b0, 4'd0);
    check("dn0.rcoN", 32'(rcoN), 0);
    drive(2'b01, 1'b0, 1'b1, 4'd0);
    check("dn0.rcoN_entN", 32'(rcoN), 1);
    drive(2'b01, 1'b0, 1'b0, 4'd0);
    tick("dn0");
    check("dn0.wrap_fixed", 32'(wrap), 1);
    // reset while wrap is high clears it without a clock
    #2 resetN = 1'b0;
    #1;
    m_q = 0; m_wrap = 1'b0;
    check("async2.wrap", 32'(wrap), 0);
    @(negedge clk);
    resetN = 1'b1;

    // out-of-range load, then up / down
    drive(2'b10, 1'b1, 1'b1, 4'd13);
    tick("ld13a");
    check("ld13a.fixed", 32'(q), 13);
    drive(2'b11, 1'b0, 1'b0, 4'd0);
    tick("oor.up");
    drive(2'b10, 1'b1, 1'b1, 4'd13);
    tick("ld13b");
    drive(2'b01, 1'b0, 1'b0, 4'd0);
    tick("oor.dn");
    check("oor.dn.fixed", 32'(q), 9);

    // clear gated by enables, hold when disabled
    drive(2'b00, 1'b1, 1'b0, 4'd0);
    tick("clr.hold");
    drive(2'b11, 1'b0, 1'b1, 4'd0);
    tick("up.hold");
    drive(2'b00, 1'b0, 1'b0, 4'd0);
    tick("clr.en");

`ifdef COUNTER_SATURATE_EN
    drive(2'b10, 1'b1, 1'b1, 4'd9);
    tick("sat.ld");
    for (int i = 0; i < 3; i++) begin
      drive(2'b11, 1'b0, 1'b0, 4'd0);
      tick("sat.up");
      check("sat.up.q9", 32'(q), 9);
      check("sat.up.w1", 32'(wrap), 1);
    end
    drive(2'b00, 1'b0, 1'b0, 4'd0);
    tick("sat.clr");
    drive(2'b01, 1'b0, 1'b0, 4'd0);
    tick("sat.dn");
    check("sat.dn.q0", 32'(q), 0);
`endif

    // randomized traffic against the model
    for (int i = 0; i < 300; i++) begin
      drive(2'($urandom_range(0, 3)), 1'($urandom_range(0, 3) == 0),
            1'($urandom_range(0, 3) == 0), 4'($urandom_range(0, 15)));
      tick("rnd");
    end

`ifndef COUNTER_SATURATE_EN
    // two-decade cascade counts 00..99 then 00
    c_enpN = 1'b0;
    @(negedge clk);
    c_resetN = 1'b1;
    for (int k = 1; k <= 101; k++) begin
      @(posedge clk);
      #1;
      check("casc", 32'(c_q_hi) * 10 + 32'(c_q_lo), 32'(k % 100));
      @(negedge clk);
    end
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire
